gpio_emu_multi: RTL
===================

// Module: gpio_emu_multi
// PURPOSE
//  Parametrised successor to the two-axis GPIO emulator. Provides CHANNELS
//  independent GPIO ports behind one register bus (saddress/srd/swr).
//  Adds per-channel latch counters, sticky status flags, a combined
//  interrupt and a bus-error pulse. Sits between the system bus and the
//  emulated GPIO pins.
// PARAMETERS
//  CHANNELS   2         number of GPIO channels (1..16)
//  DATA_W     32        GPIO and bus data width
//  ADDR_W     16        bus address width
//  CNT_W      8         latch counter width per channel
//  BASE_ADDR  16'h6ba0  address of channel 0, offset 0
//  STRIDE     16'h0010  address distance between channels (>=5)
// PORTS
//  clk             in   1               system clock, rising edge
//  reset           in   1               synchronous reset, active-high
//  saddress        in   ADDR_W          bus address
//  srd             in   1               read strobe (level; rising edge acts)
//  swr             in   1               write strobe (level; rising edge acts)
//  sdata_in        in   DATA_W          write data
//  sdata_out       out  DATA_W          registered read data
//  bus_err         out  1               1-cycle pulse: access to unmapped address
//  gpio_in         in   CHANNELS*DATA_W pin inputs, channel c at [c*DATA_W +: DATA_W]
//  gpio_latch      in   CHANNELS        per-channel capture strobe (rising edge acts)
//  gpio_out        out  CHANNELS*DATA_W OUT registers
//  gpio_in_s_insp  out  CHANNELS*DATA_W IN snapshot registers (inspection)
//  latch_count     out  CHANNELS*CNT_W  CNT registers
//  irq             out  1               OR over channels of (STATUS[2:0] & IRQEN[2:0])
// BEHAVIOUR
//  - Register map: addr = BASE_ADDR + c*STRIDE + off. Offsets:
//    0 OUT (RW), 1 IN (RO), 2 CNT (RO; any write clears),
//    3 STATUS (W1C), 4 IRQEN (RW, bits[2:0]).
//  - STATUS bits: [0] new_data, [1] overrun, [2] cnt_wrap. Upper bits read 0.
//  - All inputs are synchronous to clk. Edge detect uses one register per
//    strobe: an event occurs when the strobe is 1 and its previous value is 0.
//  - Reset: outputs, registers and STATUS become 0. Edge registers become 1,
//    so a strobe held high across reset deassert does not fire.
//    Reset in mid-access drops the access.
//  - Latch event on channel c, on the detecting edge:
//    gpio_in_s_insp[c] <= gpio_in[c]; CNT += 1 (wraps all-ones -> 0 and
//    sets cnt_wrap); sets overrun if new_data is already 1; sets new_data.
//  - Write event: performed on the detecting edge. gpio_out updates at the
//    same edge, so it is visible one cycle after the swr rise is sampled.
//  - Read event: sdata_out loads on the detecting edge and holds until the
//    next read. Reading IN clears new_data.
//  - Unmapped address: offset >= 5, channel >= CHANNELS, or below BASE_ADDR.
//    Writes are ignored. Reads return 0. Both pulse bus_err high for 1 cycle.
//    Writes to IN are ignored with no error.
//  - srd and swr rising in the same cycle: the write executes, the read is
//    ignored, and sdata_out keeps its previous value.
//  - Same-cycle collisions on one channel:
//    - Latch vs IN read: the read returns the old snapshot; new_data ends at 1.
//    - Latch vs STATUS W1C: set wins for any bit the event sets.
//    - Latch vs CNT write: CNT ends at 1.
//  - irq is combinational from registered STATUS and IRQEN; no extra latency.
// TESTING
//  1 reset=1 for 2 clk -> gpio_out=0, sdata_out=0, CNT=0, irq=0;
//    gpio_latch held 1 through reset release -> no capture.
//  2 Write 32'h123fffaa to 16'h6ba0, then 16'h6bb0 -> channel 0 and channel 1
//    gpio_out = 32'h123fffaa; read back returns the same value.
//  3 gpio_in ch1=32'h123fffaa, pulse gpio_latch[1] -> read 16'h6bb1 gives
//    32'h123fffaa, CNT(16'h6bb2)=1; STATUS reads 1 before the IN read, 0 after.
//  4 Two latches without an IN read, IRQEN=3'b010 -> STATUS=3, irq=1;
//    write 2 to STATUS -> STATUS=1, irq=0.
//  5 256 latch pulses with CNT_W=8 -> CNT=0 and cnt_wrap=1; write CNT in the
//    same cycle as a latch -> CNT=1.
//  6 Read 16'hffff and write 16'h6ba7 -> sdata_out=0 and bus_err pulses once
//    per access; registers unchanged. srd+swr rise together -> write done,
//    sdata_out unchanged.

Source files
------------

// File: rtl/gpio_emu_multi.sv
// Multi-channel GPIO emulator: CHANNELS register-mapped GPIO ports with latch
// counters, sticky status, combined interrupt and bus-error pulse.

module gpio_emu_lane #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hit,
    input  logic [2:0]        off,
    input  logic              wr_ev,
    input  logic              rd_ev,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] gpio_in,
    input  logic              latch,
    output logic [DATA_W-1:0] gpio_out,
    output logic [DATA_W-1:0] snap,
    output logic [CNT_W-1:0]  cnt,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);
    logic       latch_q, latch_ev;
    logic       wr_out, wr_cnt, wr_st, wr_ien, rd_in;
    logic [2:0] status, status_nx, irqen;

    assign latch_ev = latch & ~latch_q;
    assign wr_out   = wr_ev & hit & (off == 3'd0);
    assign wr_cnt   = wr_ev & hit & (off == 3'd2);
    assign wr_st    = wr_ev & hit & (off == 3'd3);
    assign wr_ien   = wr_ev & hit & (off == 3'd4);
    assign rd_in    = rd_ev & hit & (off == 3'd1);
    assign irq      = |(status & irqen);

    // Clears are applied first so a same-edge latch event wins on its bits.
    always_comb begin
        status_nx = status;
        if (wr_st) status_nx = status_nx & ~wdata[2:0];
        if (rd_in) status_nx[0] = 1'b0;
        if (latch_ev) begin
            status_nx[0] = 1'b1;
            if (status[0]) status_nx[1] = 1'b1;
            if (cnt == '1 && !wr_cnt) status_nx[2] = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                3'd0:    rdata = gpio_out;
                3'd1:    rdata = snap;
                3'd2:    rdata = DATA_W'(cnt);
                3'd3:    rdata = DATA_W'(status);
                3'd4:    rdata = DATA_W'(irqen);
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q  <= 1'b1;
            gpio_out <= '0;
            snap     <= '0;
            cnt      <= '0;
            status   <= '0;
            irqen    <= '0;
        end else begin
            latch_q <= latch;
            status  <= status_nx;
            if (wr_out)   gpio_out <= wdata;
            if (wr_ien)   irqen    <= wdata[2:0];
            if (latch_ev) snap     <= gpio_in;
            if (wr_cnt)        cnt <= latch_ev ? CNT_W'(1) : '0;
            else if (latch_ev) cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

module gpio_emu_multi #(
    parameter int              CHANNELS  = 2,
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 16,
    parameter int              CNT_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h6ba0,
    parameter int              STRIDE    = 16'h0010
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            saddress,
    input  logic                         srd,
    input  logic                         swr,
    input  logic [DATA_W-1:0]            sdata_in,
    output logic [DATA_W-1:0]            sdata_out,
    output logic                         bus_err,
    input  logic [CHANNELS*DATA_W-1:0]   gpio_in,
    input  logic [CHANNELS-1:0]          gpio_latch,
    output logic [CHANNELS*DATA_W-1:0]   gpio_out,
    output logic [CHANNELS*DATA_W-1:0]   gpio_in_s_insp,
    output logic [CHANNELS*CNT_W-1:0]    latch_count,
    output logic                         irq
);
    logic                             srd_q, swr_q, rd_ev, wr_ev;
    logic                             below, mapped;
    logic [ADDR_W-1:0]                rel;
    logic [ADDR_W:0]                  relx;
    logic [CHANNELS-1:0]              hit, lane_irq;
    logic [CHANNELS-1:0][2:0]         off;
    logic [CHANNELS-1:0][DATA_W-1:0]  lane_rd;
    logic [DATA_W-1:0]                rd_mux;

    // A write rising together with a read suppresses the read.
    assign wr_ev  = swr & ~swr_q;
    assign rd_ev  = srd & ~srd_q & ~wr_ev;
    assign below  = saddress < BASE_ADDR;
    assign rel    = saddress - BASE_ADDR;
    assign relx   = {1'b0, rel};
    assign mapped = |hit;
    assign irq    = |lane_irq;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        localparam logic [ADDR_W:0] LO = (ADDR_W+1)'(c*STRIDE);
        localparam logic [ADDR_W:0] HI = (ADDR_W+1)'(c*STRIDE + 5);
        logic [ADDR_W:0] d;
        assign d      = relx - LO;
        assign hit[c] = !below && (relx >= LO) && (relx < HI);
        assign off[c] = d[2:0];

        gpio_emu_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .hit      (hit[c]),
            .off      (off[c]),
            .wr_ev    (wr_ev),
            .rd_ev    (rd_ev),
            .wdata    (sdata_in),
            .gpio_in  (gpio_in[c*DATA_W +: DATA_W]),
            .latch    (gpio_latch[c]),
            .gpio_out (gpio_out[c*DATA_W +: DATA_W]),
            .snap     (gpio_in_s_insp[c*DATA_W +: DATA_W]),
            .cnt      (latch_count[c*CNT_W +: CNT_W]),
            .rdata    (lane_rd[c]),
            .irq      (lane_irq[c])
        );
    end

    // Lanes gate their own read data, so unmapped reads collapse to zero.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) rd_mux = rd_mux | lane_rd[c];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            srd_q     <= 1'b1;
            swr_q     <= 1'b1;
            sdata_out <= '0;
            bus_err   <= 1'b0;
        end else begin
            srd_q   <= srd;
            swr_q   <= swr;
            bus_err <= (rd_ev | wr_ev) & ~mapped;
            if (rd_ev) sdata_out <= rd_mux;
        end
    end
endmodule
